// File: rtl/shot_sequencer.sv
// Shot sequencer: runs nshot reset/arm/run shots across NPROC proc_cores.
// Build option: define SHOT_TIMEOUT_EN to include the per-shot watchdog.
module shot_sequencer #(
    parameter int NPROC         = 4,
    parameter int SHOTCNT_WIDTH = 32,
    parameter int RST_CYCLES    = 2,
    parameter int ARM_CYCLES    = 4,
    parameter int TIMEOUT_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stb_start,
    input  logic                     stb_abort,
    input  logic [SHOTCNT_WIDTH-1:0] nshot,
    input  logic [NPROC-1:0]         proc_mask,
    input  logic [NPROC-1:0]         proc_end,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    output logic                     proc_reset,
    output logic                     shot_busy,
    output logic                     stb_shot_start,
    output logic [SHOTCNT_WIDTH-1:0] shot_cnt,
    output logic                     last_shot_done,
    output logic                     stb_aborted,
    output logic                     timeout_err
);

    localparam int AW = $clog2(ARM_CYCLES + 2);
    localparam int RW = (TIMEOUT_WIDTH > AW) ? TIMEOUT_WIDTH : AW;
    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [CW-1:0] RST_INIT = CW'(RST_CYCLES - 1);
    localparam logic [RW-1:0] ARM_VAL  = RW'(ARM_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        RST,
        RUN
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [CW-1:0]            rst_cnt_q;
    logic [CW-1:0]            rst_cnt_d;
    logic [RW-1:0]            run_cnt_q;
    logic [RW-1:0]            run_cnt_d;
    logic [SHOTCNT_WIDTH-1:0] nshot_q;
    logic [SHOTCNT_WIDTH-1:0] nshot_d;
    logic [NPROC-1:0]         mask_q;
    logic [NPROC-1:0]         mask_d;
    logic [SHOTCNT_WIDTH-1:0] cnt_d;
    logic [SHOTCNT_WIDTH-1:0] cnt_inc;
    logic                     tmo_err_d;
    logic                     start_d;
    logic                     done_d;
    logic                     abort_d;
    logic                     all_end;
    logic                     armed;
    logic                     complete;
    logic                     is_last;
    logic                     timeout_hit;

    // Unmasked processors must all report end once the arming window is over
    assign all_end  = &(proc_end | ~mask_q);
    assign armed    = (run_cnt_q >= ARM_VAL);
    assign complete = (state_q == RUN) && armed && all_end;
    assign cnt_inc  = shot_cnt + SHOTCNT_WIDTH'(1);
    assign is_last  = (cnt_inc == nshot_q);

`ifdef SHOT_TIMEOUT_EN
    logic [RW-1:0] tmo_last;

    // Watchdog fires on the last allowed RUN cycle unless the shot completes
    assign tmo_last    = RW'(timeout_cycles) - RW'(1);
    assign timeout_hit = (state_q == RUN) &&
                         (timeout_cycles != '0) &&
                         (run_cnt_q == tmo_last) &&
                         !complete;
`else
    logic unused_tmo;

    assign unused_tmo  = &{1'b0, timeout_cycles};
    assign timeout_hit = 1'b0;
`endif

    // Next-state, counter and pulse decode; abort outranks everything
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        run_cnt_d = run_cnt_q;
        nshot_d   = nshot_q;
        mask_d    = mask_q;
        cnt_d     = shot_cnt;
        tmo_err_d = timeout_err;
        start_d   = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (stb_start && !stb_abort) begin
                    cnt_d     = '0;
                    tmo_err_d = 1'b0;
                    if (nshot != '0) begin
                        nshot_d   = nshot;
                        mask_d    = proc_mask;
                        rst_cnt_d = RST_INIT;
                        state_d   = RST;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RST: begin
                if (stb_abort) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (rst_cnt_q == '0) begin
                    state_d   = RUN;
                    run_cnt_d = '0;
                    start_d   = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q - CW'(1);
                end
            end
            RUN: begin
                if (stb_abort) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (complete) begin
                    cnt_d = cnt_inc;
                    if (is_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = RST;
                        rst_cnt_d = RST_INIT;
                    end
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    abort_d   = 1'b1;
                    tmo_err_d = 1'b1;
                end else if (run_cnt_q != '1) begin
                    run_cnt_d = run_cnt_q + RW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, latched run setup and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            rst_cnt_q      <= '0;
            run_cnt_q      <= '0;
            nshot_q        <= '0;
            mask_q         <= '0;
            shot_cnt       <= '0;
            proc_reset     <= 1'b1;
            shot_busy      <= 1'b0;
            stb_shot_start <= 1'b0;
            last_shot_done <= 1'b0;
            stb_aborted    <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            state_q        <= state_d;
            rst_cnt_q      <= rst_cnt_d;
            run_cnt_q      <= run_cnt_d;
            nshot_q        <= nshot_d;
            mask_q         <= mask_d;
            shot_cnt       <= cnt_d;
            proc_reset     <= (state_d != RUN);
            shot_busy      <= (state_d != IDLE);
            stb_shot_start <= start_d;
            last_shot_done <= done_d;
            stb_aborted    <= abort_d;
            timeout_err    <= tmo_err_d;
        end
    end

endmodule

// File: tb/tb_shot_sequencer.sv
// Bench for shot_sequencer: per-cycle compare against a shot-timeline model.
// Expectations adapt to whether SHOT_TIMEOUT_EN is defined.
module tb_shot_sequencer;

    localparam int NP  = 4;
    localparam int SW  = 32;
    localparam int RST = 2;
    localparam int ARM = 4;
    localparam int TW  = 24;
    localparam int BIG = 32'h7fff_ffff;

`ifdef SHOT_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          stb_start;
    logic          stb_abort;
    logic [SW-1:0] nshot;
    logic [NP-1:0] proc_mask;
    logic [NP-1:0] proc_end;
    logic [TW-1:0] timeout_cycles;
    logic          proc_reset;
    logic          shot_busy;
    logic          stb_shot_start;
    logic [SW-1:0] shot_cnt;
    logic          last_shot_done;
    logic          stb_aborted;
    logic          timeout_err;

    shot_sequencer #(
        .NPROC(NP), .SHOTCNT_WIDTH(SW), .RST_CYCLES(RST),
        .ARM_CYCLES(ARM), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .stb_start(stb_start), .stb_abort(stb_abort),
        .nshot(nshot), .proc_mask(proc_mask),
        .proc_end(proc_end), .timeout_cycles(timeout_cycles),
        .proc_reset(proc_reset), .shot_busy(shot_busy),
        .stb_shot_start(stb_shot_start), .shot_cnt(shot_cnt),
        .last_shot_done(last_shot_done), .stb_aborted(stb_aborted),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic          rst;
        logic          busy;
        logic          ss;
        logic          lsd;
        logic          ab;
        logic          tmo;
        logic [SW-1:0] cnt;
    } obs_t;

    int checks = 0;
    int errors = 0;

    int s, nsh, abort_at, xstart, tmo_val, end_mode, sw_at;
    int nrun, ndone, stop_at, prev_cnt, last;
    bit acc, by_abort, by_tmo, prev_tmo;
    logic [3:0] msk, const_end, end_a, end_b;
    int R[16];
    int C[16];
    int dly[16][4];

    // Stimulus: proc_end level seen by the DUT in cycle c
    function automatic logic [3:0] end_at(int c);
        logic [3:0] v;
        int k;
        v = 4'b0;
        if (end_mode == 1) return const_end;
        if (end_mode == 2) return (c < sw_at) ? end_a : end_b;
        k = -1;
        for (int j = 0; j < nrun; j++) if (R[j] <= c) k = j;
        if (k < 0 || c > C[k]) return 4'b0;
        for (int i = 0; i < 4; i++) v[i] = ((c - R[k]) >= dly[k][i]);
        return v;
    endfunction

    // Model: lay out the shot timeline as RUN-start / end cycles
    task automatic plan_run();
        int c;
        nrun = 0; ndone = 0; by_abort = 0; by_tmo = 0;
        acc = (abort_at != s);
        stop_at = s;
        last = s + 3;
        if (!acc || nsh == 0) return;
        c = s + 1 + RST;
        for (int k = 0; k < nsh; k++) begin
            R[k] = c;
            C[k] = BIG;
            if (abort_at > s && abort_at < R[k]) begin
                stop_at = abort_at; by_abort = 1; last = stop_at + 3;
                return;
            end
            nrun = k + 1;
            for (c = R[k]; ; c++) begin
                if (c == abort_at) begin
                    C[k] = c; stop_at = c; by_abort = 1; last = c + 3;
                    return;
                end
                if (c - R[k] >= ARM && (&(end_at(c) | ~msk))) break;
                if (TMO_ON && tmo_val != 0 && c - R[k] == tmo_val - 1) begin
                    C[k] = c; stop_at = c; by_tmo = 1; last = c + 3;
                    return;
                end
                if (c - R[k] > 4000) begin
                    $display("FAIL plan_guard shot=%0d got no end, need end", k);
                    $fatal(1);
                end
            end
            C[k] = c;
            ndone = k + 1;
            c = c + 1 + RST;
        end
        stop_at = C[nsh-1];
        last = stop_at + 3;
    endtask

    // Model: expected registered outputs during cycle c
    function automatic obs_t exp_at(int c);
        obs_t e;
        e.rst = 1'b1; e.busy = 1'b0; e.ss = 1'b0;
        e.lsd = 1'b0; e.ab = 1'b0;
        e.tmo = prev_tmo; e.cnt = prev_cnt;
        if (!acc || c <= s) return e;
        e.cnt = 0;
        e.tmo = 1'b0;
        if (nsh == 0) begin
            e.lsd = (c == s + 1);
            return e;
        end
        e.busy = (c <= stop_at);
        for (int k = 0; k < nrun; k++) begin
            if (c >= R[k] && c <= C[k]) e.rst = 1'b0;
            if (c == R[k]) e.ss = 1'b1;
        end
        for (int k = 0; k < ndone; k++) if (C[k] < c) e.cnt = e.cnt + 1;
        if (c == stop_at + 1) begin
            e.ab  = by_abort || by_tmo;
            e.lsd = !(by_abort || by_tmo);
        end
        if (by_tmo && c > stop_at) e.tmo = 1'b1;
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.rst = proc_reset; o.busy = shot_busy; o.ss = stb_shot_start;
        o.lsd = last_shot_done; o.ab = stb_aborted; o.tmo = timeout_err;
        o.cnt = shot_cnt;
        return o;
    endfunction

    function automatic string fmt(obs_t v);
        return $sformatf("rst=%b busy=%b ss=%b lsd=%b ab=%b tmo=%b cnt=%0d",
                         v.rst, v.busy, v.ss, v.lsd, v.ab, v.tmo, v.cnt);
    endfunction

    // Drive inputs for cycle c; nshot/mask are noise except at the start
    task automatic drive_cycle(int c);
        stb_start      = (c == s) || (c == xstart);
        stb_abort      = (c == abort_at);
        nshot          = (c == s) ? SW'(nsh) : SW'($urandom);
        proc_mask      = (c == s) ? msk : 4'($urandom);
        proc_end       = end_at(c);
        timeout_cycles = TW'(tmo_val);
    endtask

    task automatic setup(int n, logic [3:0] m, int mode);
        @(negedge clk);
        s = cyc; nsh = n; msk = m; end_mode = mode;
        abort_at = -1; xstart = -1; tmo_val = 0;
    endtask

    task automatic close_scn();
        obs_t e;
        e = exp_at(last);
        prev_cnt = e.cnt;
        prev_tmo = e.tmo;
    endtask

    task automatic test_reset();
        obs_t o, e, r;
        r.rst = 1'b1; r.busy = 0; r.ss = 0; r.lsd = 0;
        r.ab = 0; r.tmo = 0; r.cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = observe(); checks++;
            if (o !== r) begin
                errors++;
                $display("FAIL reset_values got %s need %s", fmt(o), fmt(r));
            end
        end
        reset = 1'b0; prev_cnt = 0; prev_tmo = 0;
        setup(3, 4'hF, 1); const_end = 4'hF; plan_run();
        for (int c = s; c <= C[2]; c++) begin
            if (c != s) @(negedge clk);
            o = observe(); e = exp_at(c); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_run c=%0d got %s need %s", c - s, fmt(o), fmt(e));
            end
            drive_cycle(c);
            if (c == C[2]) reset = 1'b1;
        end
        @(negedge clk);
        o = observe(); checks++;
        if (o !== r) begin
            errors++;
            $display("FAIL reset_mid_run got %s need %s", fmt(o), fmt(r));
        end
        reset = 1'b0; prev_cnt = 0; prev_tmo = 0;
    endtask

    task automatic test_multi_shot();
        obs_t o, e;
        setup(3, 4'hF, 0);
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) dly[k][i] = 10;
        plan_run();
        for (int c = s; c <= last; c++) begin
            if (c != s) @(negedge clk);
            o = observe(); e = exp_at(c); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL multi_shot c=%0d got %s need %s", c - s, fmt(o), fmt(e));
            end
            drive_cycle(c);
        end
        close_scn();
    endtask

    task automatic test_constant_end();
        obs_t o, e;
        setup(2, 4'hF, 1); const_end = 4'hF; plan_run();
        for (int c = s; c <= last; c++) begin
            if (c != s) @(negedge clk);
            o = observe(); e = exp_at(c); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL const_end c=%0d got %s need %s", c - s, fmt(o), fmt(e));
            end
            drive_cycle(c);
        end
        close_scn();
    endtask

    task automatic test_mask();
        obs_t o, e;
        setup(1, 4'b0101, 2);
        end_a = 4'b1010; end_b = 4'b0101; sw_at = s + 50;
        plan_run();
        for (int c = s; c <= last; c++) begin
            if (c != s) @(negedge clk);
            o = observe(); e = exp_at(c); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mask c=%0d got %s need %s", c - s, fmt(o), fmt(e));
            end
            drive_cycle(c);
        end
        close_scn();
        setup(2, 4'b0000, 1); const_end = 4'b0000; plan_run();
        for (int c = s; c <= last; c++) begin
            if (c != s) @(negedge clk);
            o = observe(); e = exp_at(c); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL zero_mask c=%0d got %s need %s", c - s, fmt(o), fmt(e));
            end
            drive_cycle(c);
        end
        close_scn();
    endtask

    task automatic test_abort();
        obs_t o, e;
        setup(5, 4'hF, 0);
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < 4; i++) dly[k][i] = 10;
        plan_run();
        abort_at = R[2] + $urandom_range(0, 6);
        xstart = abort_at;
        plan_run();
        for (int c = s; c <= last; c++) begin
            if (c != s) @(negedge clk);
            o = observe(); e = exp_at(c); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort c=%0d got %s need %s", c - s, fmt(o), fmt(e));
            end
            drive_cycle(c);
        end
        close_scn();
    endtask

    task automatic test_abort_idle();
        obs_t o, e;
        setup(2, 4'hF, 1); const_end = 4'hF;
        abort_at = s;
        plan_run();
        last = s + 6;
        for (int c = s; c <= last; c++) begin
            if (c != s) @(negedge clk);
            o = observe(); e = exp_at(c); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort_idle c=%0d got %s need %s", c - s, fmt(o), fmt(e));
            end
            drive_cycle(c);
        end
        close_scn();
    endtask

    task automatic test_zero_shots();
        obs_t o, e;
        setup(0, 4'hF, 1); const_end = 4'hF; plan_run();
        for (int c = s; c <= last; c++) begin
            if (c != s) @(negedge clk);
            o = observe(); e = exp_at(c); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL zero_shots c=%0d got %s need %s", c - s, fmt(o), fmt(e));
            end
            drive_cycle(c);
        end
        close_scn();
    endtask

    task automatic test_timeout();
        obs_t o, e;
        setup(2, 4'hF, 1); const_end = 4'h0; tmo_val = 20;
        abort_at = s + 40;
        plan_run();
        for (int c = s; c <= last; c++) begin
            if (c != s) @(negedge clk);
            o = observe(); e = exp_at(c); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL timeout c=%0d got %s need %s", c - s, fmt(o), fmt(e));
            end
            drive_cycle(c);
        end
        close_scn();
        setup(1, 4'hF, 1); const_end = 4'hF; plan_run();
        for (int c = s; c <= last; c++) begin
            if (c != s) @(negedge clk);
            o = observe(); e = exp_at(c); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL timeout_clear c=%0d got %s need %s", c - s, fmt(o), fmt(e));
            end
            drive_cycle(c);
        end
        close_scn();
    endtask

    task automatic test_random();
        obs_t o, e;
        for (int r = 0; r < 12; r++) begin
            setup($urandom_range(0, 4), 4'($urandom), 0);
            for (int k = 0; k < 4; k++)
                for (int i = 0; i < 4; i++) dly[k][i] = $urandom_range(0, 12);
            tmo_val = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 24) : 0;
            plan_run();
            if (nsh != 0 && $urandom_range(0, 2) == 0) begin
                abort_at = $urandom_range(s + 1, stop_at);
                plan_run();
            end
            if (nsh != 0 && $urandom_range(0, 1) == 1)
                xstart = $urandom_range(s + 1, stop_at);
            for (int c = s; c <= last; c++) begin
                if (c != s) @(negedge clk);
                o = observe(); e = exp_at(c); checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL random r=%0d c=%0d got %s need %s", r, c - s, fmt(o), fmt(e));
                end
                drive_cycle(c);
            end
            close_scn();
        end
    endtask

    initial begin
        reset = 1'b1; stb_start = 1'b0; stb_abort = 1'b0;
        nshot = '0; proc_mask = '0; proc_end = '0; timeout_cycles = '0;
        nrun = 0; ndone = 0; end_mode = 1; const_end = 4'h0;
        test_reset();
        test_multi_shot();
        test_constant_end();
        test_mask();
        test_abort();
        test_abort_idle();
        test_zero_shots();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish, need finish");
        $fatal(1);
    end

endmodule

// File: doc/shot_sequencer.md
Name: shot_sequencer

Overview:
- Parametrised successor to the fixed 4-processor shot-control logic in the DSP top level.
- Runs a programmable number of shots across NPROC proc_core instances. Per-processor participation is maskable.
- Generates the shared processor reset and enforces a reset hold and an end-detect arming window per shot.
- Reports shot count, completion, abort and (optionally) timeout status to the register block.

Parameters:
NPROC, 4, number of proc_core instances supervised
SHOTCNT_WIDTH, 32, width of nshot and shot_cnt
RST_CYCLES, 2, cycles proc_reset is held high before each shot (>=1)
ARM_CYCLES, 4, RUN cycles during which proc_end is ignored (>=0)
TIMEOUT_WIDTH, 24, width of timeout_cycles

Ports:
clk  in  1  DSP clock; all logic on its rising edge
reset  in  1  synchronous, active-high
stb_start  in  1  one-cycle run request
stb_abort  in  1  one-cycle abort request
nshot  in  SHOTCNT_WIDTH  shots per run; sampled on accepted stb_start
proc_mask  in  NPROC  1 = processor participates; sampled on accepted stb_start
proc_end  in  NPROC  per-processor end level (noop & not busy)
timeout_cycles  in  TIMEOUT_WIDTH  maximum RUN length per shot; 0 = disabled
proc_reset  out  1  shared proc_core reset
shot_busy  out  1  high while a run is in progress
stb_shot_start  out  1  pulse on the first cycle of each shot's RUN
shot_cnt  out  SHOTCNT_WIDTH  completed shots in the current or last run
last_shot_done  out  1  one-cycle pulse after the final shot completes
stb_aborted  out  1  one-cycle pulse when a run ends by abort or timeout
timeout_err  out  1  sticky timeout flag

Behaviour:
- All outputs are registered.
- Values on reset: state IDLE, proc_reset=1, shot_busy=0, shot_cnt=0, all pulses 0, timeout_err=0, latched nshot and mask cleared.
- Reset mid-run: returns to these values on the next edge, with no pulses.

State machine:
- IDLE: proc_reset=1, shot_busy=0.
  - stb_start with nshot!=0: latch nshot and proc_mask, shot_cnt<=0, clear timeout_err, go RST with rst_cnt<=RST_CYCLES-1.
  - stb_start with nshot==0: stay IDLE, last_shot_done=1 on the next cycle, shot_cnt<=0.
- RST: proc_reset=1, shot_busy=1. Decrement rst_cnt; at 0 go RUN with run_cnt<=0. proc_reset is high for exactly RST_CYCLES cycles.
- RUN: proc_reset=0, shot_busy=1.
  - stb_shot_start=1 in the first RUN cycle only.
  - run_cnt increments each cycle and saturates.
  - Completion is evaluated only when run_cnt>=ARM_CYCLES: complete = &(proc_end | ~mask_lat).
  - On complete, shot_cnt<=shot_cnt+1 (same edge).
  - If shot_cnt+1==nshot_lat: go IDLE and pulse last_shot_done in the first IDLE cycle.
  - Otherwise go RST.
- With proc_end constantly high, the shot period is RST_CYCLES+ARM_CYCLES+1 cycles.
- An all-zero mask completes the shot as soon as the arming window ends.

Priority and boundary rules:
- stb_abort in RST or RUN: go IDLE next edge. proc_reset=1, stb_aborted=1 for one cycle, shot_cnt holds, no last_shot_done.
- stb_abort has priority over completion and over stb_start in the same cycle.
- stb_abort in IDLE has no effect, but any stb_start in that same cycle is ignored.
- stb_start while shot_busy=1 is ignored. nshot and proc_mask changes outside an accepted start are ignored.
- shot_cnt never wraps. Maximum nshot is 2^SHOTCNT_WIDTH-1.

Optional Feature:
Macro: SHOT_TIMEOUT_EN.

Defined:
- A per-shot watchdog is active.
- In RUN, if timeout_cycles!=0, run_cnt==timeout_cycles-1 and complete==0:
  - go IDLE next edge, set timeout_err=1 (sticky), pulse stb_aborted, shot_cnt holds.
- Completion in the same cycle wins over timeout.
- timeout_err is cleared only by reset or an accepted stb_start.

Undefined:
- The watchdog logic is not built.
- timeout_cycles is ignored and timeout_err is tied 0.

Test Plan:
All scenarios use NPROC=4, RST_CYCLES=2, ARM_CYCLES=4.
1. nshot=3, mask=4'hF, all proc_end rise 10 cycles after each stb_shot_start -> three stb_shot_start pulses; shot_cnt steps 1,2,3; proc_reset high for 2 cycles between shots; one last_shot_done; shot_busy falls with it.
2. proc_end held 4'hF from start, nshot=2 -> shot_cnt increments exactly 7 cycles apart; first stb_shot_start 3 cycles after stb_start; no early completion during cycles 0-3 of RUN.
3. mask=4'b0101, proc_end=4'b1010 for 50 cycles, then 4'b0101 -> no completion while 4'b1010; completion 1 cycle after 4'b0101 is seen.
4. nshot=5, stb_abort in the RUN of shot 3 -> proc_reset=1 next cycle, stb_aborted pulse, shot_cnt=2, no last_shot_done; a stb_start in the same cycle as the abort is ignored.
5. nshot=0 -> last_shot_done 1 cycle after stb_start; proc_reset never deasserts; shot_cnt=0.
6. SHOT_TIMEOUT_EN defined, timeout_cycles=20, proc_end=0 -> RUN lasts 20 cycles; timeout_err=1, stb_aborted pulse, shot_cnt=0; next stb_start clears timeout_err.
